// File: rtl/climate_pkg.sv
// rtl/climate_pkg.sv - climate controller mode encoding and fan speed helper
package climate_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_HEAT  = 2'd1,
    MODE_COOL  = 2'd2,
    MODE_FAULT = 2'd3
  } mode_t;

  // Level 0 means fan off; level k runs at base + (k-1)*inc.
  function automatic int rps_for_level(input int level, input int base, input int inc);
    return (level == 0) ? 0 : base + (level - 1) * inc;
  endfunction

endpackage

// File: rtl/fault_filter.sv
// rtl/fault_filter.sv - consecutive-sample range debounce for the temperature sensor
module fault_filter #(
  parameter int W         = 8,
  parameter int S_MIN     = -40,
  parameter int S_MAX     = 100,
  parameter int FAULT_CNT = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [W-1:0] sensor,
  input  logic                sample_valid,
  output logic                in_fault,
  output logic                fault_next
);

  localparam int CW = $clog2(FAULT_CNT + 1);

  logic [CW-1:0] bad_cnt;
  logic [CW-1:0] good_cnt;
  logic          in_range;

  assign in_range = (int'(sensor) >= S_MIN) && (int'(sensor) <= S_MAX);

  // fault_next lets the controller react on the same edge that in_fault updates.
  always_comb begin
    fault_next = in_fault;
    if (sample_valid) begin
      if (!in_range && int'(bad_cnt) >= FAULT_CNT - 1)
        fault_next = 1'b1;
      else if (in_range && int'(good_cnt) >= FAULT_CNT - 1)
        fault_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bad_cnt  <= '0;
      good_cnt <= '0;
      in_fault <= 1'b0;
    end else if (sample_valid) begin
      in_fault <= fault_next;
      if (in_range) begin
        bad_cnt <= '0;
        if (int'(good_cnt) < FAULT_CNT) good_cnt <= good_cnt + 1'b1;
      end else begin
        good_cnt <= '0;
        if (int'(bad_cnt) < FAULT_CNT) bad_cnt <= bad_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/climate_ctrl.sv
// rtl/climate_ctrl.sv - heater/cooler controller with hysteresis, fan levels and sensor fault handling
module climate_ctrl
  import climate_pkg::*;
#(
  parameter int W          = 8,
  parameter int T_HEAT_ON  = 15,
  parameter int T_HEAT_OFF = 25,
  parameter int T_COOL_ON  = 35,
  parameter int T_STEP     = 5,
  parameter int FAN_LEVELS = 3,
  parameter int FAN_BASE   = 4,
  parameter int FAN_INC    = 2,
  parameter int FAN_W      = 4,
  parameter int MIN_DWELL  = 16,
  parameter int S_MIN      = -40,
  parameter int S_MAX      = 100,
  parameter int FAULT_CNT  = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [W-1:0] sensor,
  input  logic                sample_valid,
  output logic                cooler,
  output logic                heater,
  output logic [FAN_W-1:0]    fan_rps,
  output logic [1:0]          mode,
  output logic                fault
);

  localparam int DW      = $clog2(MIN_DWELL + 1);
  localparam int TOP_RPS = rps_for_level(FAN_LEVELS, FAN_BASE, FAN_INC);

  if (FAN_LEVELS < 1 || FAN_LEVELS > 7 || TOP_RPS > 2**FAN_W - 1 ||
      T_HEAT_ON >= T_HEAT_OFF || T_HEAT_OFF >= T_COOL_ON) begin : g_param_check
    $error("climate_ctrl: illegal parameter combination");
  end

  mode_t          state, state_n;
  logic [2:0]     level, level_n;
  logic [DW-1:0]  dwell, dwell_n;
  logic           dwell_sat;
  logic           heater_n, cooler_n, fault_n;
  logic [FAN_W-1:0] fan_n;
  logic           in_fault, flt_next;
  int             s, up_thr, dn_thr;

  fault_filter #(
    .W(W), .S_MIN(S_MIN), .S_MAX(S_MAX), .FAULT_CNT(FAULT_CNT)
  ) u_fault_filter (
    .clk          (clk),
    .reset        (reset),
    .sensor       (sensor),
    .sample_valid (sample_valid),
    .in_fault     (in_fault),
    .fault_next   (flt_next)
  );

  assign s         = int'(sensor);
  assign up_thr    = T_COOL_ON + int'(level) * T_STEP;
  assign dn_thr    = T_COOL_ON + (int'(level) - 2) * T_STEP;
  assign dwell_sat = (int'(dwell) == MIN_DWELL);

  always_comb begin
    state_n = state;
    level_n = level;
    if (flt_next && !in_fault) begin
      state_n = MODE_FAULT;
      level_n = '0;
    end else if (state == MODE_FAULT) begin
      if (!flt_next) state_n = MODE_IDLE;
    end else if (sample_valid) begin
      case (state)
        MODE_IDLE: begin
          if (s > T_COOL_ON && dwell_sat) begin
            state_n = MODE_COOL;
            level_n = 3'd1;
          end else if (s < T_HEAT_ON && dwell_sat) begin
            state_n = MODE_HEAT;
          end
        end
        MODE_HEAT: if (s > T_HEAT_OFF && dwell_sat) state_n = MODE_IDLE;
        MODE_COOL: begin
          // Fan level steps are not dwell-gated; only leaving COOL is.
          if (int'(level) < FAN_LEVELS && s > up_thr)
            level_n = level + 3'd1;
          else if (level > 3'd1 && s < dn_thr)
            level_n = level - 3'd1;
          else if (level == 3'd1 && s < T_COOL_ON && dwell_sat) begin
            state_n = MODE_IDLE;
            level_n = '0;
          end
        end
        default: ;
      endcase
    end

    dwell_n = (state_n != state) ? '0 : (dwell_sat ? dwell : dwell + 1'b1);

    heater_n = (state_n == MODE_HEAT);
    cooler_n = (state_n == MODE_COOL);
    fault_n  = (state_n == MODE_FAULT);
    fan_n    = '0;
    if (state_n == MODE_COOL)
      fan_n = FAN_W'(rps_for_level(int'(level_n), FAN_BASE, FAN_INC));
    else if (state_n == MODE_FAULT)
      fan_n = FAN_W'(TOP_RPS);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= MODE_IDLE;
      level   <= '0;
      dwell   <= '0;
      heater  <= 1'b0;
      cooler  <= 1'b0;
      fault   <= 1'b0;
      fan_rps <= '0;
    end else begin
      state   <= state_n;
      level   <= level_n;
      dwell   <= dwell_n;
      heater  <= heater_n;
      cooler  <= cooler_n;
      fault   <= fault_n;
      fan_rps <= fan_n;
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_climate_ctrl.sv
// tb/tb_climate_ctrl.sv - directed self-checking bench for climate_ctrl
module tb_climate_ctrl;

  logic              clk;
  logic              reset;
  logic signed [7:0] sensor;
  logic              sample_valid;
  logic              cooler;
  logic              heater;
  logic [3:0]        fan_rps;
  logic [1:0]        mode;
  logic              fault;

  int total = 0;
  int bad   = 0;

  climate_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .sensor       (sensor),
    .sample_valid (sample_valid),
    .cooler       (cooler),
    .heater       (heater),
    .fan_rps      (fan_rps),
    .mode         (mode),
    .fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int m, input int h, input int c,
                         input int f, input int flt);
    chk({tag, ".mode"},   32'(mode),    m);
    chk({tag, ".heater"}, 32'(heater),  h);
    chk({tag, ".cooler"}, 32'(cooler),  c);
    chk({tag, ".fan"},    32'(fan_rps), f);
    chk({tag, ".fault"},  32'(fault),   flt);
  endtask

  // Present one sample for one rising edge, then settle just after the edge.
  task automatic step(input int v, input bit vld);
    @(negedge clk);
    sensor       = 8'(v);
    sample_valid = vld;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b0;
    sensor       = '0;
    sample_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 0, 0, 0, 0, 0);
    reset = 1'b1;

    // Edge k after release leaves dwell at k.
    for (int i = 0; i < 10; i++) step(20, 1);
    chk_all("idle20", 0, 0, 0, 0, 0);

    step(35, 1);
    chk_all("cool_eq_thr", 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(36, 1);
      chk("cool_dwell_gate", 32'(mode), 0);
    end
    step(36, 1);
    chk_all("cool_l1", 2, 0, 1, 4, 0);
    step(41, 1); chk_all("cool_l2", 2, 0, 1, 6, 0);
    step(46, 1); chk_all("cool_l3", 2, 0, 1, 8, 0);
    step(50, 1); chk_all("cool_top", 2, 0, 1, 8, 0);
    step(39, 1); chk_all("cool_dn2", 2, 0, 1, 6, 0);
    step(34, 1); chk_all("cool_dn1", 2, 0, 1, 4, 0);
    step(34, 1); chk_all("cool_hold_l1", 2, 0, 1, 4, 0);
    for (int i = 0; i < 5; i++) step(-100, 0);
    chk_all("invalid_hold", 2, 0, 1, 4, 0);
    for (int i = 0; i < 5; i++) step(35, 1);
    chk_all("cool_eq_hold", 2, 0, 1, 4, 0);
    step(34, 1);
    chk_all("cool_exit", 0, 0, 0, 0, 0);

    for (int i = 0; i < 16; i++) begin
      step(10, 1);
      chk("heat_dwell_gate", 32'(heater), 0);
    end
    step(10, 1);
    chk_all("heat_on", 1, 1, 0, 0, 0);
    step(26, 1);
    chk_all("heat_exit_gated", 1, 1, 0, 0, 0);
    for (int i = 0; i < 15; i++) step(25, 1);
    chk_all("heat_eq_hold", 1, 1, 0, 0, 0);
    step(26, 1);
    chk_all("heat_exit", 0, 0, 0, 0, 0);

    for (int i = 0; i < 16; i++) step(0, 0);
    step(36, 1); chk_all("f_cool_l1", 2, 0, 1, 4, 0);
    step(41, 1); chk_all("f_cool_l2", 2, 0, 1, 6, 0);
    step(120, 1); chk("f_oor1", 32'(fault), 0);
    step(120, 1); chk("f_oor2", 32'(fault), 0);
    step(120, 1); chk_all("f_enter", 3, 0, 0, 8, 1);
    step(20, 1); step(20, 1); step(120, 1);
    chk_all("f_hold", 3, 0, 0, 8, 1);
    step(20, 1); step(20, 1);
    chk_all("f_hold2", 3, 0, 0, 8, 1);
    step(20, 1);
    chk_all("f_exit", 0, 0, 0, 0, 0);

    step(-41, 1); step(-41, 1); step(100, 1);
    chk_all("smax_in_range", 0, 0, 0, 0, 0);
    step(-41, 1); step(-41, 1);
    chk("smin_pending", 32'(fault), 0);
    step(-41, 1);
    chk_all("smin_fault", 3, 0, 0, 8, 1);
    for (int i = 0; i < 3; i++) step(-40, 1);
    chk_all("smin_exit", 0, 0, 0, 0, 0);

    for (int i = 0; i < 16; i++) step(0, 0);
    step(10, 1);
    chk_all("rst_heat", 1, 1, 0, 0, 0);
    @(negedge clk);
    sensor       = 8'(10);
    sample_valid = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk_all("rst_async", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("rst_held", 0, 0, 0, 0, 0);
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step(10, 1);
      chk("rst_dwell_gate", 32'(heater), 0);
    end
    step(10, 1);
    chk_all("rst_heat_again", 1, 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
